// File: rtl/noc_tx_sequencer.sv
// Outbound NoC sequencer: captures one write request into a 96-bit packet,
// stamps a sequence number and serialises it as six 16-bit flits.
module noc_tx_sequencer #(
    parameter logic [15:0] SRC_ADDR = 16'h0000,
    parameter logic [15:0] SEQ_INIT = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [15:0] wr_addr,
    input  logic [2:0]  wr_size,
    input  logic [7:0]  wr_flags,
    input  logic [31:0] wr_data,
    output logic        flit_valid,
    input  logic        flit_ready,
    output logic [15:0] flit_data,
    output logic        flit_last,
    output logic        busy,
    output logic [15:0] seq_num,
    output logic [15:0] sent_cnt
);

    // Handshake rule on both sides: a transfer happens at a rising edge where
    // valid && ready; a presented flit holds data/last stable until accepted.

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    localparam logic [2:0] LAST_IDX = 3'd5;

    state_t      state_q, state_d;
    logic [2:0]  fidx_q, fidx_d;
    logic [95:0] pkt_q, pkt_d;
    logic [15:0] seq_q, seq_d;
    logic [15:0] sent_q, sent_d;
    logic        accept;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            fidx_q  <= 3'd0;
            pkt_q   <= 96'd0;
            seq_q   <= SEQ_INIT;
            sent_q  <= 16'd0;
        end else begin
            state_q <= state_d;
            fidx_q  <= fidx_d;
            pkt_q   <= pkt_d;
            seq_q   <= seq_d;
            sent_q  <= sent_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        fidx_d     = fidx_q;
        pkt_d      = pkt_q;
        seq_d      = seq_q;
        sent_d     = sent_q;
        wr_ready   = 1'b0;
        flit_valid = 1'b0;
        flit_data  = 16'd0;
        flit_last  = 1'b0;
        accept     = 1'b0;

        case (state_q)
            S_IDLE: begin
                wr_ready = en && !rst;
            end
            S_SEND: begin
                flit_valid = 1'b1;
                flit_last  = (fidx_q == LAST_IDX);
                case (fidx_q)
                    3'd0:    flit_data = pkt_q[95:80];
                    3'd1:    flit_data = pkt_q[79:64];
                    3'd2:    flit_data = pkt_q[63:48];
                    3'd3:    flit_data = pkt_q[47:32];
                    3'd4:    flit_data = pkt_q[31:16];
                    3'd5:    flit_data = pkt_q[15:0];
                    default: flit_data = 16'd0;
                endcase
                // Ready during the tail lets the next packet follow with no bubble.
                wr_ready = en && !rst && (fidx_q == LAST_IDX) && flit_ready;
                if (flit_ready) begin
                    if (fidx_q != LAST_IDX) begin
                        fidx_d = 3'(fidx_q + 3'd1);
                    end else begin
                        sent_d  = sent_q + 16'd1;
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        accept = wr_valid && wr_ready;
        if (accept) begin
            pkt_d   = {SRC_ADDR, wr_addr, seq_q, 5'b00000, wr_size, wr_flags, wr_data};
            seq_d   = seq_q + 16'd1;
            fidx_d  = 3'd0;
            state_d = S_SEND;
        end
    end

    assign busy     = (state_q == S_SEND);
    assign seq_num  = seq_q;
    assign sent_cnt = sent_q;

endmodule

// File: tb/tb_noc_tx_sequencer.sv
// Bench for noc_tx_sequencer: two instances (different source address and
// initial sequence) share stimulus and are checked against a flit-queue model.
module tb_noc_tx_sequencer;

    localparam logic [15:0] SRC_A  = 16'h0003;
    localparam logic [15:0] SEQ_A  = 16'h0000;
    localparam logic [15:0] SRC_B  = 16'h00B0;
    localparam logic [15:0] SEQ_B  = 16'hFFFF;

    logic        clk = 1'b0;
    logic        rst, en, wr_valid, flit_ready;
    logic [15:0] wr_addr;
    logic [2:0]  wr_size;
    logic [7:0]  wr_flags;
    logic [31:0] wr_data;

    logic        wr_ready_a, flit_valid_a, flit_last_a, busy_a;
    logic [15:0] flit_data_a, seq_num_a, sent_cnt_a;
    logic        wr_ready_b, flit_valid_b, flit_last_b, busy_b;
    logic [15:0] flit_data_b, seq_num_b, sent_cnt_b;

    noc_tx_sequencer #(.SRC_ADDR(SRC_A), .SEQ_INIT(SEQ_A)) dut_a (
        .clk(clk), .rst(rst), .en(en), .wr_valid(wr_valid), .wr_ready(wr_ready_a),
        .wr_addr(wr_addr), .wr_size(wr_size), .wr_flags(wr_flags), .wr_data(wr_data),
        .flit_valid(flit_valid_a), .flit_ready(flit_ready), .flit_data(flit_data_a),
        .flit_last(flit_last_a), .busy(busy_a), .seq_num(seq_num_a), .sent_cnt(sent_cnt_a)
    );

    noc_tx_sequencer #(.SRC_ADDR(SRC_B), .SEQ_INIT(SEQ_B)) dut_b (
        .clk(clk), .rst(rst), .en(en), .wr_valid(wr_valid), .wr_ready(wr_ready_b),
        .wr_addr(wr_addr), .wr_size(wr_size), .wr_flags(wr_flags), .wr_data(wr_data),
        .flit_valid(flit_valid_b), .flit_ready(flit_ready), .flit_data(flit_data_b),
        .flit_last(flit_last_b), .busy(busy_b), .seq_num(seq_num_b), .sent_cnt(sent_cnt_b)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: flits still owed on the link, per instance, plus counters.
    logic [15:0] exp_qa[$];
    logic [15:0] exp_qb[$];
    logic [15:0] m_seq_a = SEQ_A;
    logic [15:0] m_seq_b = SEQ_B;
    logic [15:0] m_sent  = 16'd0;

    // Flits actually transferred, for the directed literal checks.
    logic [15:0] got_a[$];
    logic [15:0] got_b[$];
    logic        got_last[$];

    always @(negedge clk) begin
        logic exp_rdy, hs, acc;
        exp_rdy = !rst && en && (exp_qa.size() == 0 || (exp_qa.size() == 1 && flit_ready));

        check("wr_ready_a", wr_ready_a, exp_rdy);
        check("flit_valid_a", flit_valid_a, exp_qa.size() != 0);
        check("flit_data_a", flit_data_a, exp_qa.size() != 0 ? exp_qa[0] : 16'd0);
        check("flit_last_a", flit_last_a, exp_qa.size() == 1);
        check("busy_a", busy_a, exp_qa.size() != 0);
        check("seq_num_a", seq_num_a, m_seq_a);
        check("sent_cnt_a", sent_cnt_a, m_sent);
        check("wr_ready_b", wr_ready_b, exp_rdy);
        check("flit_data_b", flit_data_b, exp_qb.size() != 0 ? exp_qb[0] : 16'd0);
        check("flit_last_b", flit_last_b, exp_qb.size() == 1);
        check("flit_valid_b", flit_valid_b, exp_qb.size() != 0);
        check("seq_num_b", seq_num_b, m_seq_b);
        check("sent_cnt_b", sent_cnt_b, m_sent);

        if (!rst && flit_valid_a && flit_ready) begin
            got_a.push_back(flit_data_a);
            got_b.push_back(flit_data_b);
            got_last.push_back(flit_last_a);
        end

        // Advance the model to what the coming rising edge must produce.
        if (rst) begin
            exp_qa.delete();
            exp_qb.delete();
            m_seq_a = SEQ_A;
            m_seq_b = SEQ_B;
            m_sent  = 16'd0;
        end else begin
            hs  = (exp_qa.size() != 0) && flit_ready;
            acc = wr_valid && exp_rdy;
            if (hs) begin
                void'(exp_qa.pop_front());
                void'(exp_qb.pop_front());
                if (exp_qa.size() == 0) m_sent = m_sent + 16'd1;
            end
            if (acc) begin
                exp_qa.push_back(SRC_A);
                exp_qa.push_back(wr_addr);
                exp_qa.push_back(m_seq_a);
                exp_qa.push_back({5'b00000, wr_size, wr_flags});
                exp_qa.push_back(wr_data[31:16]);
                exp_qa.push_back(wr_data[15:0]);
                exp_qb.push_back(SRC_B);
                exp_qb.push_back(wr_addr);
                exp_qb.push_back(m_seq_b);
                exp_qb.push_back({5'b00000, wr_size, wr_flags});
                exp_qb.push_back(wr_data[31:16]);
                exp_qb.push_back(wr_data[15:0]);
                m_seq_a = m_seq_a + 16'd1;
                m_seq_b = m_seq_b + 16'd1;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic clear_log();
        got_a.delete();
        got_b.delete();
        got_last.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic send_req(input logic [15:0] a, input logic [2:0] s,
                            input logic [7:0] f, input logic [31:0] d);
        bit done;
        done = 1'b0;
        wr_addr  = a;
        wr_size  = s;
        wr_flags = f;
        wr_data  = d;
        wr_valid = 1'b1;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if (wr_ready_a) done = 1'b1;
        end
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
        wr_addr  = 16'hFFFF;
        wr_size  = 3'd7;
        wr_flags = 8'hFF;
        wr_data  = 32'hFFFF_FFFF;
        check("accept_seen", done, 1'b1);
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (!flit_valid_a && !busy_a) done = 1'b1;
        end
        check("idle_reached", done, 1'b1);
    endtask

    logic [15:0] t2_exp [6] = '{16'h0003, 16'h1234, 16'h0000, 16'h02A5, 16'hDEAD, 16'hBEEF};
    logic [15:0] t4_exp [6] = '{16'h0003, 16'h4321, 16'h0001, 16'h013C, 16'h1122, 16'h3344};

    int vcyc, zcyc;

    initial begin
        // Reset with a request pending: nothing may be accepted.
        rst = 1'b1; en = 1'b1; wr_valid = 1'b1; flit_ready = 1'b1;
        wr_addr = 16'h5555; wr_size = 3'd7; wr_flags = 8'hFF; wr_data = 32'hCAFE_F00D;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_wr_ready", wr_ready_a, 1'b0);
        check("rst_flit_valid", flit_valid_a, 1'b0);
        check("rst_flit_data", flit_data_a, 16'h0000);
        check("rst_seq_a", seq_num_a, 16'h0000);
        check("rst_seq_b", seq_num_b, 16'hFFFF);
        check("rst_sent", sent_cnt_a, 16'h0000);
        @(posedge clk);
        #1;
        rst = 1'b0;
        wr_valid = 1'b0;

        // Single packet.
        clear_log();
        send_req(16'h1234, 3'd2, 8'hA5, 32'hDEAD_BEEF);
        @(negedge clk);
        check("latency_flit0_valid", flit_valid_a, 1'b1);
        check("latency_flit0_data", flit_data_a, 16'h0003);
        wait_idle();
        check("t2_count", got_a.size(), 6);
        for (int k = 0; k < 6; k++) begin
            check("t2_flit", got_a[k], t2_exp[k]);
            check("t2_last", got_last[k], k == 5);
        end
        check("t2_seq", seq_num_a, 16'h0001);
        check("t2_sent", sent_cnt_a, 16'h0001);
        check("t2_busy", busy_a, 1'b0);

        // Backpressure on flit 2 for three cycles.
        @(posedge clk); #1;
        do_reset();
        clear_log();
        send_req(16'h1234, 3'd2, 8'hA5, 32'hDEAD_BEEF);
        vcyc = 0;
        zcyc = 0;
        fork
            begin
                repeat (2) @(posedge clk);
                #1 flit_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 flit_ready = 1'b1;
            end
            begin
                bit done;
                done = 1'b0;
                for (int i = 0; i < 40 && !done; i++) begin
                    @(negedge clk);
                    if (flit_valid_a) vcyc++;
                    if (flit_valid_a && flit_data_a == 16'h0000) zcyc++;
                    if (flit_valid_a && flit_last_a && flit_ready) done = 1'b1;
                end
            end
        join
        check("t3_total_cycles", vcyc, 9);
        check("t3_stall_cycles", zcyc, 4);
        wait_idle();
        check("t3_count", got_a.size(), 6);
        for (int k = 0; k < 6; k++) check("t3_flit", got_a[k], t2_exp[k]);

        // Back-to-back packets; instance B also covers sequence wrap.
        @(posedge clk); #1;
        do_reset();
        clear_log();
        send_req(16'h1234, 3'd2, 8'hA5, 32'hDEAD_BEEF);
        send_req(16'h4321, 3'd1, 8'h3C, 32'h1122_3344);
        @(negedge clk);
        check("t4_no_bubble_valid", flit_valid_a, 1'b1);
        check("t4_no_bubble_data", flit_data_a, 16'h0003);
        check("t4_first_done", got_a.size(), 6);
        wait_idle();
        check("t4_count", got_a.size(), 12);
        for (int k = 0; k < 6; k++) check("t4_flit", got_a[6 + k], t4_exp[k]);
        check("t4_sent", sent_cnt_a, 16'h0002);
        check("t5_src_b", got_b[0], 16'h00B0);
        check("t5_seq_first", got_b[2], 16'hFFFF);
        check("t5_seq_second", got_b[8], 16'h0000);
        check("t5_seq_after", seq_num_b, 16'h0001);

        // en dropped at flit 2 with a request pending.
        @(posedge clk); #1;
        do_reset();
        clear_log();
        send_req(16'h0BAD, 3'd0, 8'h01, 32'h0102_0304);
        repeat (2) @(posedge clk);
        #1;
        en = 1'b0;
        wr_valid = 1'b1;
        wr_addr = 16'h7777;
        wait_idle();
        repeat (3) @(negedge clk);
        check("t6_count", got_a.size(), 6);
        check("t6_sent", sent_cnt_a, 16'h0001);
        check("t6_no_ready", wr_ready_a, 1'b0);
        check("t6_no_accept_seq", seq_num_a, 16'h0001);
        check("t6_no_accept_busy", busy_a, 1'b0);
        @(posedge clk); #1;
        wr_valid = 1'b0;
        en = 1'b1;

        // Reset pulsed while flit 3 is presented.
        clear_log();
        send_req(16'h0C0C, 3'd3, 8'h80, 32'hAAAA_5555);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("t6r_flit_valid", flit_valid_a, 1'b0);
        check("t6r_flit_data", flit_data_a, 16'h0000);
        check("t6r_seq", seq_num_a, 16'h0000);
        check("t6r_sent", sent_cnt_a, 16'h0000);
        repeat (5) @(negedge clk);
        check("t6r_no_tail", got_a.size(), 3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
